// File: rtl/bus_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_n_if
// Request/grant bundle between N Wishbone masters, the shared slave and the
// N-master arbiter.
//   cyc_i   : per-master bus request (master cyc, already chip-selected)
//   lock_i  : per-master lock, suppresses forced release of the owner
//   ack_i   : slave ack
//   gnt_o   : one-hot grant, all-zero when idle
//   owner_o : index of the granted master, holds last value when idle
//   cyc_o   : slave cyc qualifier
//   ack_o   : ack steered to the owning master
//   busy_o  : a tenure is in progress
// Modport 'slave' is the arbiter side (it serves master requests);
// modport 'master' is the requester/slave-environment side.
// ---------------------------------------------------------------------------
interface bus_arbiter_n_if #(
    parameter int NMASTERS = 4,
    parameter int OW       = $clog2(NMASTERS)
) ();
    logic [NMASTERS-1:0] cyc_i;
    logic [NMASTERS-1:0] lock_i;
    logic                ack_i;
    logic [NMASTERS-1:0] gnt_o;
    logic [OW-1:0]       owner_o;
    logic                cyc_o;
    logic [NMASTERS-1:0] ack_o;
    logic                busy_o;

    modport slave (
        input  cyc_i, lock_i, ack_i,
        output gnt_o, owner_o, cyc_o, ack_o, busy_o
    );

    modport master (
        output cyc_i, lock_i, ack_i,
        input  gnt_o, owner_o, cyc_o, ack_o, busy_o
    );
endinterface

// File: rtl/bus_arbiter_n.sv
// ---------------------------------------------------------------------------
// bus_arbiter_n
// N-master Wishbone arbiter for one shared slave. Fixed-priority (MODE=0,
// index 0 highest) or round-robin (MODE=1) winner selection, one-cycle grant
// latency, no dead cycle between tenures, and a bounded hold: after MAXHOLD
// acks the owner is forced off when someone else waits, unless it holds lock.
// Ports:
//   clk_i   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : bus_arbiter_n_if.slave (cyc_i/lock_i/ack_i in,
//             gnt_o/owner_o/cyc_o/ack_o/busy_o out)
// gnt_o only moves on an edge that leaves IDLE or meets a release condition,
// so it is safe to drive the downstream adr/dat/sel/we muxes from it.
// ---------------------------------------------------------------------------
module bus_arbiter_n #(
    parameter int NMASTERS = 4,
    parameter int MODE     = 0,
    parameter int MAXHOLD  = 16,
    parameter int OW       = $clog2(NMASTERS)
) (
    input  logic           clk_i,
    input  logic           reset_n,
    bus_arbiter_n_if.slave bus
);

    // MAXHOLD=0 (unlimited) still gets a 1-bit counter that never moves.
    localparam int                  CW        = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
    localparam logic [CW-1:0]       HOLD_LAST = (MAXHOLD > 0) ? CW'(MAXHOLD - 1) : {CW{1'b0}};
    localparam logic [CW-1:0]       HOLD_ONE  = CW'(1);
    localparam logic [NMASTERS-1:0] GNT_ONE   = NMASTERS'(1);
    localparam logic [OW-1:0]       LAST_RST  = OW'(NMASTERS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NMASTERS-1:0] gnt_q,   gnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q,  last_d;
    logic [CW-1:0]       hold_q,  hold_d;

    logic                owner_req_s;
    logic                others_s;
    logic                rel_a_s;
    logic                rel_b_s;
    logic                do_grant_s;
    logic [NMASTERS-1:0] req_mask_s;
    logic [OW-1:0]       win_s;

    // Winner among req: lowest index, or first index at/after last+1 with wrap.
    function automatic logic [OW-1:0] pick_winner(input logic [NMASTERS-1:0] req,
                                                  input logic [OW-1:0]       last);
        logic [OW-1:0] w;
        logic [OW-1:0] ix;
        logic          found;
        int            idx;
        w     = {OW{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NMASTERS; k++) begin
            if (MODE == 1) begin
                idx = int'(last) + 1 + k;
                if (idx >= NMASTERS) begin
                    idx = idx - NMASTERS;
                end else begin
                    idx = idx;
                end
            end else begin
                idx = k;
            end
            ix = OW'(idx);
            if (!found && req[ix]) begin
                w     = ix;
                found = 1'b1;
            end else begin
                w     = w;
                found = found;
            end
        end
        return w;
    endfunction

    // Release conditions and the request set seen by the next arbitration.
    always_comb begin
        owner_req_s = bus.cyc_i[owner_q];
        others_s    = |(bus.cyc_i & ~gnt_q);
        rel_a_s     = (state_q == GRANT) && !owner_req_s;
        // Forced release; natural release (A) wins when both hold.
        rel_b_s     = (MAXHOLD != 0) && (state_q == GRANT) && !rel_a_s &&
                      !bus.lock_i[owner_q] && bus.ack_i &&
                      (hold_q == HOLD_LAST) && others_s;
        if (rel_b_s) begin
            req_mask_s = bus.cyc_i & ~gnt_q;
        end else begin
            req_mask_s = bus.cyc_i;
        end
        win_s = pick_winner(req_mask_s, last_q);
    end

    // Next-state for grant, owner, round-robin pointer and hold counter.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_d     = hold_q;
        do_grant_s = 1'b0;
        case (state_q)
            IDLE: begin
                do_grant_s = |bus.cyc_i;
                hold_d     = {CW{1'b0}};
            end
            GRANT: begin
                if (rel_a_s || rel_b_s) begin
                    if (|req_mask_s) begin
                        do_grant_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = {NMASTERS{1'b0}};
                        hold_d  = {CW{1'b0}};
                    end
                end else if ((MAXHOLD != 0) && bus.ack_i && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + HOLD_ONE;
                end else begin
                    // Saturate at HOLD_LAST when nobody else is waiting or lock is set.
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = {NMASTERS{1'b0}};
                hold_d  = {CW{1'b0}};
            end
        endcase
        if (do_grant_s) begin
            // Every grant, including a re-grant to the same index, restarts the tenure.
            state_d = GRANT;
            gnt_d   = GNT_ONE << win_s;
            owner_d = win_s;
            last_d  = win_s;
            hold_d  = {CW{1'b0}};
        end else begin
            state_d = state_d;
        end
    end

    // Arbiter state registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= {NMASTERS{1'b0}};
            owner_q <= {OW{1'b0}};
            last_q  <= LAST_RST;
            hold_q  <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Slave qualifiers and ack steering follow the live inputs in the same cycle.
    assign bus.gnt_o   = gnt_q;
    assign bus.owner_o = owner_q;
    assign bus.busy_o  = |gnt_q;
    assign bus.cyc_o   = |(gnt_q & bus.cyc_i);
    assign bus.ack_o   = gnt_q & {NMASTERS{bus.ack_i}};

endmodule

// File: tb/tb_bus_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_n
// Directed bench for bus_arbiter_n. Two instances share clock and reset:
//   u_fp : fixed priority, MAXHOLD=4
//   u_rr : round-robin,    MAXHOLD=16
// Inputs change on the falling edge; each step queues its expected outputs
// and compares them 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_n;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       cyc;
        logic [3:0] ack;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    bus_arbiter_n_if #(.NMASTERS(4)) ia ();
    bus_arbiter_n_if #(.NMASTERS(4)) ib ();

    bus_arbiter_n #(.NMASTERS(4), .MODE(0), .MAXHOLD(4)) u_fp (
        .clk_i   (clk),
        .reset_n (rst_n),
        .bus     (ia)
    );

    bus_arbiter_n #(.NMASTERS(4), .MODE(1), .MAXHOLD(16)) u_rr (
        .clk_i   (clk),
        .reset_n (rst_n),
        .bus     (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                            input logic ec, input logic a);
        exp_t e;
        e.tag  = tag;
        e.gnt  = eg;
        e.own  = eo;
        e.cyc  = ec;
        e.ack  = eg & {4{a}};
        e.busy = |eg;
        exp_q.push_back(e);
    endtask

    task automatic check_obs(input logic [3:0] g, input logic [1:0] o, input logic c,
                             input logic [3:0] a, input logic b);
        exp_t e;
        e = exp_q.pop_front();
        cmp({e.tag, "_gnt"},   32'(g), 32'(e.gnt));
        cmp({e.tag, "_owner"}, 32'(o), 32'(e.own));
        cmp({e.tag, "_cyc"},   32'(c), 32'(e.cyc));
        cmp({e.tag, "_ack"},   32'(a), 32'(e.ack));
        cmp({e.tag, "_busy"},  32'(b), 32'(e.busy));
    endtask

    task automatic chk_a(input string tag, input logic [3:0] eg, input logic [1:0] eo, input logic ec);
        push_exp(tag, eg, eo, ec, ia.ack_i);
        check_obs(ia.gnt_o, ia.owner_o, ia.cyc_o, ia.ack_o, ia.busy_o);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] eg, input logic [1:0] eo, input logic ec);
        push_exp(tag, eg, eo, ec, ib.ack_i);
        check_obs(ib.gnt_o, ib.owner_o, ib.cyc_o, ib.ack_o, ib.busy_o);
    endtask

    task automatic step_a(input string tag, input logic [3:0] c, input logic [3:0] l, input logic a,
                          input logic [3:0] eg, input logic [1:0] eo, input logic ec);
        @(negedge clk);
        ia.cyc_i  = c;
        ia.lock_i = l;
        ia.ack_i  = a;
        push_exp(tag, eg, eo, ec, a);
        #1;
        check_obs(ia.gnt_o, ia.owner_o, ia.cyc_o, ia.ack_o, ia.busy_o);
    endtask

    task automatic step_b(input string tag, input logic [3:0] c, input logic [3:0] l, input logic a,
                          input logic [3:0] eg, input logic [1:0] eo, input logic ec);
        @(negedge clk);
        ib.cyc_i  = c;
        ib.lock_i = l;
        ib.ack_i  = a;
        push_exp(tag, eg, eo, ec, a);
        #1;
        check_obs(ib.gnt_o, ib.owner_o, ib.cyc_o, ib.ack_o, ib.busy_o);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        ia.cyc_i  = 4'b0000;
        ia.lock_i = 4'b0000;
        ia.ack_i  = 1'b0;
        ib.cyc_i  = 4'b0000;
        ib.lock_i = 4'b0000;
        ib.ack_i  = 1'b0;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        #1;
        chk_a("a_reset", 4'b0000, 2'd0, 1'b0);
        chk_b("b_reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a tenure
        step_a("rst_req",  4'b0100, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        step_a("rst_gnt",  4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("rst_async", 4'b0000, 2'd0, 1'b0);
        step_a("rst_low",  4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        step_a("rst_idle1", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        step_a("rst_idle2", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        // Fixed priority, back-to-back tenures, idle ack ignored
        step_a("fp_req",    4'b1010, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        step_a("fp_gnt1",   4'b1010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1);
        step_a("fp_drop1",  4'b1000, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0);
        step_a("fp_gnt3",   4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1);
        step_a("fp_drop3",  4'b0000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0);
        step_a("fp_idle",   4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);
        step_a("idle_ack",  4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0);
        step_a("idle_ack2", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);

        // Bounded hold: forced release after 4 acks, then lock override
        step_a("mh_req", 4'b0101, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step_a("mh_stream", 4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
        end
        step_a("mh_forced",   4'b0101, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);
        step_a("mh_m2_drop",  4'b0001, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0);
        step_a("mh_regrant0", 4'b0101, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step_a("mh_locked", 4'b0101, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        end
        step_a("mh_unlock",     4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
        step_a("mh_unlock_rel", 4'b0101, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1);
        step_a("mh_clear",      4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0);
        step_a("mh_idle",       4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);

        // Lone streamer keeps the grant; a newcomer takes over on the next ack
        step_a("al_req", 4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_a("al_stream", 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
        end
        step_a("al_m1_req",  4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1);
        step_a("al_m1_wait", 4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1);
        step_a("al_xfer",    4'b0011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1);
        step_a("al_clear",   4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0);
        step_a("al_idle",    4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);

        // Round-robin: all request, each owner drops after one ack
        step_b("rr_req", 4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            logic [1:0] ow;
            logic [3:0] g;
            ow = 2'(k % 4);
            g  = 4'b0001 << ow;
            step_b("rr_gnt",  4'b1111,      4'b0000, 1'b1, g, ow, 1'b1);
            step_b("rr_drop", 4'b1111 & ~g, 4'b0000, 1'b0, g, ow, 1'b0);
        end
        step_b("rr_ackdrop", 4'b1100, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0);
        step_b("rr_next",    4'b1100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1);
        step_b("rr_clear",   4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0);
        step_b("rr_idle",    4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
